ex_stage: RTL and testbench

//  - MIPS32 pipeline EX stage: operand forwarding, ALU control decode, ALU with HI/LO divide state.
//  - Sits between ID/EX and EX/MEM registers; everything combinational except HI/LO.

---
 rtl/ex_stage_pkg.sv | 50 +++++
 rtl/ex_if.sv | 63 ++++++
 rtl/alu_decode.sv | 44 ++++
 rtl/forwarding_unit.sv | 58 +++++
 rtl/ex_stage.sv | 132 +++++++++++++
 tb/tb_ex_stage.sv | 336 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ex_stage_pkg.sv
// ============================================================================
// Module   : ex_stage_pkg
// Brief    : Shared encodings for the EX stage: funct / ALU-control constants,
//            internal ALU operation codes and forwarding select codes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_stage_pkg;

   localparam logic [5:0] FUNCT_SLL  = 6'h00;
   localparam logic [5:0] FUNCT_JR   = 6'h08;
   localparam logic [5:0] FUNCT_MFHI = 6'h10;
   localparam logic [5:0] FUNCT_MFLO = 6'h12;
   localparam logic [5:0] FUNCT_MUL  = 6'h18;
   localparam logic [5:0] FUNCT_DIV  = 6'h1A;
   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;

   localparam logic [2:0] ALUCTRL_R   = 3'b000;
   localparam logic [2:0] ALUCTRL_ADD = 3'b001;
   localparam logic [2:0] ALUCTRL_SUB = 3'b010;
   localparam logic [2:0] ALUCTRL_OR  = 3'b011;
   localparam logic [2:0] ALUCTRL_LUI = 3'b100;

   localparam int LINK_REG = 31;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_OR   = 4'd2,
      ALU_SLL  = 4'd3,
      ALU_LUI  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_MUL  = 4'd6,
      ALU_DIV  = 4'd7,
      ALU_MFHI = 4'd8,
      ALU_MFLO = 4'd9
   } alu_op_t;

   typedef enum logic [1:0] {
      FWD_REG   = 2'b00,
      FWD_MEMWB = 2'b01,
      FWD_EXMEM = 2'b10
   } fwd_sel_t;

endpackage

`default_nettype wire

// File: rtl/ex_if.sv
// ============================================================================
// Module   : ex_if
// Brief    : ID/EX operands, hazard-side pipeline fields and EX results.
//            master = pipeline side driving the stage, slave = the EX stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_if #(
   parameter int W  = 32,
   parameter int RW = 5
);
   logic [W-1:0]  rs_data;
   logic [W-1:0]  rt_data;
   logic [W-1:0]  imm;
   logic [4:0]    shamt;
   logic [5:0]    funct;
   logic [2:0]    alu_ctrl;
   logic          alu_src;
   logic          reg_dst;
   logic          link;
   logic          no_dest;
   logic [RW-1:0] idex_reg_rs;
   logic [RW-1:0] idex_reg_rt;
   logic [RW-1:0] idex_reg_rd;
   logic          exmem_reg_write;
   logic          exmem_mem_write;
   logic [RW-1:0] exmem_reg_rd;
   logic [RW-1:0] exmem_reg_rt;
   logic [W-1:0]  exmem_alu_out;
   logic          memwb_reg_write;
   logic          memwb_mem_to_reg;
   logic [RW-1:0] memwb_reg_rd;
   logic [W-1:0]  memwb_data;

   logic [W-1:0]  alu_out;
   logic [W-1:0]  store_data;
   logic [RW-1:0] write_reg;
   logic [1:0]    for_a;
   logic [1:0]    for_b;
   logic          for_c;

   modport master (
      output rs_data, rt_data, imm, shamt, funct, alu_ctrl, alu_src, reg_dst,
             link, no_dest, idex_reg_rs, idex_reg_rt, idex_reg_rd,
             exmem_reg_write, exmem_mem_write, exmem_reg_rd, exmem_reg_rt,
             exmem_alu_out, memwb_reg_write, memwb_mem_to_reg, memwb_reg_rd,
             memwb_data,
      input  alu_out, store_data, write_reg, for_a, for_b, for_c
   );

   modport slave (
      input  rs_data, rt_data, imm, shamt, funct, alu_ctrl, alu_src, reg_dst,
             link, no_dest, idex_reg_rs, idex_reg_rt, idex_reg_rd,
             exmem_reg_write, exmem_mem_write, exmem_reg_rd, exmem_reg_rt,
             exmem_alu_out, memwb_reg_write, memwb_mem_to_reg, memwb_reg_rd,
             memwb_data,
      output alu_out, store_data, write_reg, for_a, for_b, for_c
   );

endinterface

`default_nettype wire

// File: rtl/alu_decode.sv
// ============================================================================
// Module   : alu_decode
// Brief    : Maps the main-control opcode class and R-type funct field onto
//            an internal ALU operation; anything unrecognised becomes add.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decode
   import ex_stage_pkg::*;
(
   input  logic [2:0] alu_ctrl,
   input  logic [5:0] funct,
   output alu_op_t    alu_op
);

   always_comb begin
      alu_op = ALU_ADD;
      case (alu_ctrl)
         ALUCTRL_R: begin
            case (funct)
               FUNCT_ADD:  alu_op = ALU_ADD;
               FUNCT_JR:   alu_op = ALU_ADD;
               FUNCT_SUB:  alu_op = ALU_SUB;
               FUNCT_SLL:  alu_op = ALU_SLL;
               FUNCT_SLT:  alu_op = ALU_SLT;
               FUNCT_MUL:  alu_op = ALU_MUL;
               FUNCT_DIV:  alu_op = ALU_DIV;
               FUNCT_MFHI: alu_op = ALU_MFHI;
               FUNCT_MFLO: alu_op = ALU_MFLO;
               default:    alu_op = ALU_ADD;
            endcase
         end
         ALUCTRL_ADD: alu_op = ALU_ADD;
         ALUCTRL_SUB: alu_op = ALU_SUB;
         ALUCTRL_OR:  alu_op = ALU_OR;
         ALUCTRL_LUI: alu_op = ALU_LUI;
         default:     alu_op = ALU_ADD;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/forwarding_unit.sv
// ============================================================================
// Module   : forwarding_unit
// Brief    : EX operand forwarding selects (EX/MEM over MEM/WB) and the
//            MEM-stage store-data forward from a load in MEM/WB.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module forwarding_unit
   import ex_stage_pkg::*;
#(
   parameter int RW = 5
) (
   input  logic [RW-1:0] idex_reg_rs,
   input  logic [RW-1:0] idex_reg_rt,
   input  logic          exmem_reg_write,
   input  logic          exmem_mem_write,
   input  logic [RW-1:0] exmem_reg_rd,
   input  logic [RW-1:0] exmem_reg_rt,
   input  logic          memwb_reg_write,
   input  logic          memwb_mem_to_reg,
   input  logic [RW-1:0] memwb_reg_rd,
   output fwd_sel_t      for_a,
   output fwd_sel_t      for_b,
   output logic          for_c
);

   logic w_exmem_live;
   logic w_memwb_live;

   // r0 is hard-wired zero, so a pending write to it never forwards
   assign w_exmem_live = exmem_reg_write && (exmem_reg_rd != '0);
   assign w_memwb_live = memwb_reg_write && (memwb_reg_rd != '0);

   always_comb begin
      for_a = FWD_REG;
      if (w_exmem_live && (exmem_reg_rd == idex_reg_rs)) begin
         for_a = FWD_EXMEM;
      end else if (w_memwb_live && (memwb_reg_rd == idex_reg_rs)) begin
         for_a = FWD_MEMWB;
      end
   end

   always_comb begin
      for_b = FWD_REG;
      if (w_exmem_live && (exmem_reg_rd == idex_reg_rt)) begin
         for_b = FWD_EXMEM;
      end else if (w_memwb_live && (memwb_reg_rd == idex_reg_rt)) begin
         for_b = FWD_MEMWB;
      end
   end

   assign for_c = exmem_mem_write && w_memwb_live && memwb_mem_to_reg &&
                  (memwb_reg_rd == exmem_reg_rt);

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// Module   : ex_stage
// Brief    : MIPS32 EX stage - operand forwarding muxes, ALU decode, ALU and
//            the HI/LO divide registers. Only HI/LO hold state.
// Config   : EX_DIV_EN - when defined, HI/LO and the divider are built;
//            otherwise div/mfhi/mflo return zero and clk/rst are unused.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int W  = 32,
   parameter int RW = 5
) (
   input  logic clk,
   input  logic rst,
   ex_if.slave  bus
);

   localparam logic [RW-1:0] c_link_reg = RW'(LINK_REG);

   fwd_sel_t     w_for_a;
   fwd_sel_t     w_for_b;
   logic         w_for_c;
   alu_op_t      w_alu_op;
   logic [W-1:0] w_op_a;
   logic [W-1:0] w_op_b;
   logic [W-1:0] w_store_data;
   logic [W-1:0] w_alu_out;
   logic [W-1:0] w_hi;
   logic [W-1:0] w_lo;

   forwarding_unit #(.RW(RW)) u_fwd (
      .idex_reg_rs      (bus.idex_reg_rs),
      .idex_reg_rt      (bus.idex_reg_rt),
      .exmem_reg_write  (bus.exmem_reg_write),
      .exmem_mem_write  (bus.exmem_mem_write),
      .exmem_reg_rd     (bus.exmem_reg_rd),
      .exmem_reg_rt     (bus.exmem_reg_rt),
      .memwb_reg_write  (bus.memwb_reg_write),
      .memwb_mem_to_reg (bus.memwb_mem_to_reg),
      .memwb_reg_rd     (bus.memwb_reg_rd),
      .for_a            (w_for_a),
      .for_b            (w_for_b),
      .for_c            (w_for_c)
   );

   alu_decode u_dec (
      .alu_ctrl (bus.alu_ctrl),
      .funct    (bus.funct),
      .alu_op   (w_alu_op)
   );

   always_comb begin
      case (w_for_a)
         FWD_EXMEM: w_op_a = bus.exmem_alu_out;
         FWD_MEMWB: w_op_a = bus.memwb_data;
         default:   w_op_a = bus.rs_data;
      endcase
   end

   always_comb begin
      case (w_for_b)
         FWD_EXMEM: w_store_data = bus.exmem_alu_out;
         FWD_MEMWB: w_store_data = bus.memwb_data;
         default:   w_store_data = bus.rt_data;
      endcase
   end

   assign w_op_b = bus.alu_src ? bus.imm : w_store_data;

`ifdef EX_DIV_EN
   logic [W-1:0] r_hi;
   logic [W-1:0] r_lo;
   logic [W-1:0] w_quot;
   logic [W-1:0] w_rem;
   logic         w_div_fire;

   // Truncating signed divide: remainder carries the dividend's sign
   assign w_quot     = $signed(w_op_a) / $signed(w_op_b);
   assign w_rem      = $signed(w_op_a) % $signed(w_op_b);
   assign w_div_fire = (w_alu_op == ALU_DIV) && (w_op_b != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_div_fire) begin
         r_hi <= w_rem;
         r_lo <= w_quot;
      end
   end

   assign w_hi = r_hi;
   assign w_lo = r_lo;
`else
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;
   assign w_hi = '0;
   assign w_lo = '0;
`endif

   always_comb begin
      w_alu_out = '0;
      case (w_alu_op)
         ALU_ADD:  w_alu_out = w_op_a + w_op_b;
         ALU_SUB:  w_alu_out = w_op_a - w_op_b;
         ALU_OR:   w_alu_out = w_op_a | w_op_b;
         ALU_SLL:  w_alu_out = w_op_b << bus.shamt;
         ALU_LUI:  w_alu_out = {w_op_b[15:0], {(W-16){1'b0}}};
         ALU_SLT:  w_alu_out = {{(W-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
         // Low W bits of a product are identical for signed and unsigned operands
         ALU_MUL:  w_alu_out = w_op_a * w_op_b;
         ALU_MFHI: w_alu_out = w_hi;
         ALU_MFLO: w_alu_out = w_lo;
         default:  w_alu_out = '0;
      endcase
   end

   assign bus.alu_out    = w_alu_out;
   assign bus.store_data = w_store_data;
   assign bus.for_a      = w_for_a;
   assign bus.for_b      = w_for_b;
   assign bus.for_c      = w_for_c;
   assign bus.write_reg  = bus.no_dest ? (bus.link ? c_link_reg : '0)
                                       : (bus.reg_dst ? bus.idex_reg_rd : bus.idex_reg_rt);

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
// Module   : tb_ex_stage
// Brief    : Randomised and directed checks of ex_stage against a behavioural
//            model of forwarding, destination select, ALU and HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_stage;

`ifdef EX_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic [5:0]  fn_list [10] = '{6'h20, 6'h22, 6'h00, 6'h2A, 6'h08,
                                 6'h18, 6'h1A, 6'h10, 6'h12, 6'h3F};

   ex_if #(.W(32), .RW(5)) bus ();

   ex_stage #(.W(32), .RW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- behavioural reference ----------------
   function automatic logic [1:0] exp_sel(input logic [4:0] src);
      if (bus.exmem_reg_write && bus.exmem_reg_rd != 5'd0 && bus.exmem_reg_rd == src) return 2'b10;
      if (bus.memwb_reg_write && bus.memwb_reg_rd != 5'd0 && bus.memwb_reg_rd == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [31:0] fwd_value(input logic [1:0] sel, input logic [31:0] reg_v);
      if (sel == 2'b10) return bus.exmem_alu_out;
      if (sel == 2'b01) return bus.memwb_data;
      return reg_v;
   endfunction

   function automatic logic [31:0] exp_a();
      return fwd_value(exp_sel(bus.idex_reg_rs), bus.rs_data);
   endfunction

   function automatic logic [31:0] exp_store();
      return fwd_value(exp_sel(bus.idex_reg_rt), bus.rt_data);
   endfunction

   function automatic logic [31:0] exp_b();
      return bus.alu_src ? bus.imm : exp_store();
   endfunction

   function automatic logic exp_for_c();
      return bus.exmem_mem_write && bus.memwb_reg_write && bus.memwb_mem_to_reg &&
             bus.memwb_reg_rd != 5'd0 && bus.memwb_reg_rd == bus.exmem_reg_rt;
   endfunction

   function automatic logic [4:0] exp_wreg();
      if (bus.no_dest) return bus.link ? 5'd31 : 5'd0;
      return bus.reg_dst ? bus.idex_reg_rd : bus.idex_reg_rt;
   endfunction

   function automatic logic [31:0] exp_alu();
      logic [31:0] a;
      logic [31:0] b;
      longint      sa;
      longint      sb;
      longint      prod;
      a    = exp_a();
      b    = exp_b();
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      prod = sa * sb;
      case (bus.alu_ctrl)
         3'd0: begin
            case (bus.funct)
               6'h22:   return a - b;
               6'h00:   return b << bus.shamt;
               6'h2A:   return (sa < sb) ? 32'd1 : 32'd0;
               6'h18:   return prod[31:0];
               6'h1A:   return 32'd0;
               6'h10:   return m_hi;
               6'h12:   return m_lo;
               default: return a + b;
            endcase
         end
         3'd2:    return a - b;
         3'd3:    return a | b;
         3'd4:    return {b[15:0], 16'h0000};
         default: return a + b;
      endcase
   endfunction

   // HI/LO model: a div seen at an edge updates them unless B is zero; reset wins
   always @(posedge clk) begin : hilo_model
      longint sa;
      longint sb;
      sa = longint'($signed(exp_a()));
      sb = longint'($signed(exp_b()));
      if (rst) begin
         m_hi <= 32'd0;
         m_lo <= 32'd0;
      end else if (DIV_EN && bus.alu_ctrl == 3'd0 && bus.funct == 6'h1A && sb != 0) begin
         m_lo <= 32'(sa / sb);
         m_hi <= 32'(sa % sb);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive_defaults();
      bus.rs_data = '0;          bus.rt_data = '0;          bus.imm = '0;
      bus.shamt = '0;            bus.funct = 6'h20;         bus.alu_ctrl = 3'd0;
      bus.alu_src = 1'b0;        bus.reg_dst = 1'b0;        bus.link = 1'b0;
      bus.no_dest = 1'b0;        bus.idex_reg_rs = '0;      bus.idex_reg_rt = '0;
      bus.idex_reg_rd = '0;      bus.exmem_reg_write = 1'b0; bus.exmem_mem_write = 1'b0;
      bus.exmem_reg_rd = '0;     bus.exmem_reg_rt = '0;     bus.exmem_alu_out = '0;
      bus.memwb_reg_write = 1'b0; bus.memwb_mem_to_reg = 1'b0; bus.memwb_reg_rd = '0;
      bus.memwb_data = '0;
   endtask

   task automatic rand_operands();
      bus.rs_data     = $urandom();
      bus.rt_data     = $urandom();
      bus.imm         = $urandom();
      bus.shamt       = 5'($urandom_range(0, 31));
      bus.alu_src     = 1'($urandom_range(0, 1));
      bus.reg_dst     = 1'($urandom_range(0, 1));
      bus.link        = 1'($urandom_range(0, 1));
      bus.no_dest     = 1'($urandom_range(0, 1));
      bus.idex_reg_rs = 5'($urandom_range(0, 31));
      bus.idex_reg_rt = 5'($urandom_range(0, 31));
      bus.idex_reg_rd = 5'($urandom_range(0, 31));
   endtask

   task automatic check_all(input string tag);
      check({tag, ".alu"},   bus.alu_out,           exp_alu());
      check({tag, ".store"}, bus.store_data,        exp_store());
      check({tag, ".wreg"},  32'(bus.write_reg),    32'(exp_wreg()));
      check({tag, ".fa"},    32'(bus.for_a),        32'(exp_sel(bus.idex_reg_rs)));
      check({tag, ".fb"},    32'(bus.for_b),        32'(exp_sel(bus.idex_reg_rt)));
      check({tag, ".fc"},    32'(bus.for_c),        32'(exp_for_c()));
   endtask

   task automatic do_div(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      drive_defaults();
      bus.rs_data = a;
      bus.rt_data = b;
      bus.funct   = 6'h1A;
      #1 check("div.out", bus.alu_out, 32'd0);
   endtask

   task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
      @(negedge clk);
      drive_defaults();
      bus.funct = 6'h10;
      #1 check({tag, ".hi"}, bus.alu_out, DIV_EN ? hi : 32'd0);
      @(negedge clk);
      bus.funct = 6'h12;
      #1 check({tag, ".lo"}, bus.alu_out, DIV_EN ? lo : 32'd0);
   endtask

   task automatic alu_case(input string tag, input logic [2:0] ctrl, input logic [31:0] exp);
      @(negedge clk);
      bus.alu_ctrl = ctrl;
      #1 check(tag, bus.alu_out, exp);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1;
      drive_defaults();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      read_hilo("reset", 32'd0, 32'd0);

      // R-type with forwarding idle
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         drive_defaults();
         rand_operands();
         bus.funct = fn_list[$urandom_range(0, 9)];
         #1 check_all($sformatf("rtype%0d", i));
      end

      // Non-R opcode classes
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive_defaults();
         rand_operands();
         bus.alu_ctrl = 3'($urandom_range(1, 7));
         #1 check_all($sformatf("ctrl%0d", i));
      end

      // Forwarding with colliding indices
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         drive_defaults();
         rand_operands();
         bus.funct            = fn_list[$urandom_range(0, 5)];
         bus.idex_reg_rs      = 5'($urandom_range(0, 3));
         bus.idex_reg_rt      = 5'($urandom_range(0, 3));
         bus.exmem_reg_rd     = 5'($urandom_range(0, 3));
         bus.exmem_reg_rt     = 5'($urandom_range(0, 3));
         bus.memwb_reg_rd     = 5'($urandom_range(0, 3));
         bus.exmem_reg_write  = 1'($urandom_range(0, 1));
         bus.exmem_mem_write  = 1'($urandom_range(0, 1));
         bus.memwb_reg_write  = 1'($urandom_range(0, 1));
         bus.memwb_mem_to_reg = 1'($urandom_range(0, 1));
         bus.exmem_alu_out    = $urandom();
         bus.memwb_data       = $urandom();
         #1 check_all($sformatf("fwd%0d", i));
      end

      // Signed multiply corners
      @(negedge clk);
      drive_defaults();
      bus.rs_data = 32'hFFFF_FFFF;
      bus.rt_data = 32'd1;
      bus.funct   = 6'h18;
      #1 check("mul.m1x1", bus.alu_out, 32'hFFFF_FFFF);
      bus.rt_data = 32'd0;
      #1 check("mul.m1x0", bus.alu_out, 32'd0);

      // Opcode-class sweep on a fixed immediate
      @(negedge clk);
      drive_defaults();
      bus.rs_data = 32'h0F0F_1111;
      bus.imm     = 32'h1234_ABCD;
      bus.alu_src = 1'b1;
      alu_case("sweep.lui", 3'd4, 32'hABCD_0000);
      alu_case("sweep.ori", 3'd3, 32'h1F3F_BBDD);
      alu_case("sweep.beq", 3'd2, 32'hFCDA_6544);
      alu_case("sweep.lw",  3'd1, 32'h2143_BCDE);
      alu_case("sweep.res", 3'd7, 32'h2143_BCDE);

      // Directed forwarding
      @(negedge clk);
      drive_defaults();
      bus.exmem_reg_write = 1'b1;
      bus.exmem_reg_rd    = 5'd5;
      bus.idex_reg_rs     = 5'd5;
      bus.idex_reg_rt     = 5'd7;
      bus.exmem_alu_out   = 32'hDEAD_0000;
      bus.rs_data         = 32'h1111_1111;
      bus.rt_data         = 32'd1;
      #1 check("fwdA.sel", 32'(bus.for_a), 32'd2);
      check("fwdA.alu", bus.alu_out, 32'hDEAD_0001);
      bus.exmem_reg_rd = 5'd0;
      bus.idex_reg_rs  = 5'd0;
      #1 check("fwdA.r0", 32'(bus.for_a), 32'd0);
      check("fwdA.r0alu", bus.alu_out, 32'h1111_1112);

      @(negedge clk);
      drive_defaults();
      bus.memwb_reg_write = 1'b1;
      bus.memwb_reg_rd    = 5'd9;
      bus.idex_reg_rt     = 5'd9;
      bus.memwb_data      = 32'hCAFE_F00D;
      bus.exmem_alu_out   = 32'h0BAD_BEEF;
      bus.exmem_reg_write = 1'b1;
      bus.exmem_reg_rd    = 5'd4;
      #1 check("fwdB.memwb", 32'(bus.for_b), 32'd1);
      check("fwdB.mwdata", bus.store_data, 32'hCAFE_F00D);
      bus.exmem_reg_rd = 5'd9;
      #1 check("fwdB.both", 32'(bus.for_b), 32'd2);
      check("fwdB.exdata", bus.store_data, 32'h0BAD_BEEF);

      @(negedge clk);
      drive_defaults();
      bus.exmem_mem_write  = 1'b1;
      bus.exmem_reg_rt     = 5'd12;
      bus.memwb_reg_write  = 1'b1;
      bus.memwb_mem_to_reg = 1'b1;
      bus.memwb_reg_rd     = 5'd12;
      #1 check("fwdC.load", 32'(bus.for_c), 32'd1);
      bus.memwb_mem_to_reg = 1'b0;
      #1 check("fwdC.noload", 32'(bus.for_c), 32'd0);

      // Destination select
      @(negedge clk);
      drive_defaults();
      bus.idex_reg_rt = 5'd3;
      bus.idex_reg_rd = 5'd17;
      bus.no_dest = 1'b1;
      bus.link    = 1'b1;
      #1 check("wreg.link", 32'(bus.write_reg), 32'd31);
      bus.link = 1'b0;
      #1 check("wreg.none", 32'(bus.write_reg), 32'd0);
      bus.no_dest = 1'b0;
      bus.reg_dst = 1'b1;
      #1 check("wreg.rd", 32'(bus.write_reg), 32'd17);

      // HI/LO divide behaviour
      do_div(32'd6, 32'd3);
      read_hilo("div6_3", 32'd0, 32'd2);
      do_div(32'd1, 32'd3);
      read_hilo("div1_3", 32'd1, 32'd0);
      do_div(32'd11, 32'd3);
      read_hilo("div11_3", 32'd2, 32'd3);
      do_div(32'd5, 32'd0);
      read_hilo("div5_0", 32'd2, 32'd3);
      do_div(32'hFFFF_FFF9, 32'd2);
      read_hilo("divm7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      do_div(32'd10, 32'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive_defaults();
      read_hilo("rstdiv", 32'd0, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
